sparc_tlu_zcmp_pipe: RTL

- Parametrised, pipelined successor to the TLU 64b zero compare.
- Tests a masked operand for all-zero (mode 0) or for equality with a reference value (mode 1), tagged with a thread id.
- Uses a two-stage chunked reduction with valid/ready flow control.
- Keeps per-thread sticky match flags and a saturating match counter, for tick/compare-style match detection in the TLU.

---
 rtl/sparc_tlu_zcmp_pkg.sv | 17 +
 rtl/sparc_tlu_zcmp_chunk.sv | 31 +++
 rtl/sparc_tlu_zcmp_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sparc_tlu_zcmp_pkg.sv
// -----------------------------------------------------------------------------
// sparc_tlu_zcmp_pkg
// Shared definitions for the pipelined TLU zero/equality compare.
//   - nchk(): number of stage-1 reduction chunks for a given width/chunk size
//   - ZCMP_ZERO / ZCMP_EQ: compare mode encodings
// -----------------------------------------------------------------------------
package sparc_tlu_zcmp_pkg;

  localparam logic ZCMP_ZERO = 1'b0;
  localparam logic ZCMP_EQ   = 1'b1;

  // ceil(width / chunk); the last chunk is zero-padded when it does not divide.
  function automatic int unsigned nchk(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/sparc_tlu_zcmp_chunk.sv
// -----------------------------------------------------------------------------
// sparc_tlu_zcmp_chunk
// Combinational masked zero/equality flag for one CHUNK-bit slice.
// Ports:
//   i_data    operand slice
//   i_ref_val reference slice (used only in ZCMP_EQ mode)
//   i_mask    1 = bit is don't-care
//   i_mode    ZCMP_ZERO / ZCMP_EQ
//   o_zero    1 = every unmasked bit of the formed operand is zero
// -----------------------------------------------------------------------------
module sparc_tlu_zcmp_chunk
  import sparc_tlu_zcmp_pkg::*;
#(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] i_data,
  input  logic [CHUNK-1:0] i_ref_val,
  input  logic [CHUNK-1:0] i_mask,
  input  logic             i_mode,
  output logic             o_zero
);

  logic [CHUNK-1:0] w_cmp;
  logic [CHUNK-1:0] w_x;

  // Equality is reduced to zero-detect by XOR-ing with the reference.
  assign w_cmp  = (i_mode == ZCMP_EQ) ? i_ref_val : '0;
  assign w_x    = (i_data ^ w_cmp) & ~i_mask;
  assign o_zero = ~|w_x;

endmodule

// File: rtl/sparc_tlu_zcmp_pipe.sv
// -----------------------------------------------------------------------------
// sparc_tlu_zcmp_pipe
// Two-stage pipelined masked zero / equality compare with valid/ready flow
// control, per-thread sticky match flags and a saturating match counter.
// Stage 1 registers NCHK chunk-zero flags; stage 2 registers their AND.
// Ports:
//   clk, reset             core clock, asynchronous active-high reset
//   in_vld/in_rdy          request handshake
//   in_data/in_ref/in_mask operand, reference, don't-care mask
//   in_mode, in_tid        compare mode, thread tag
//   out_vld/out_rdy        result handshake
//   out_zero, out_tid      match result and its tag (from stage-2 registers)
//   sticky_hit/sticky_clr  per-thread sticky match flags and their clears
//   match_cnt/cnt_clr      saturating delivered-match count and its clear
//   busy                   either pipeline stage holds valid data
// TIDW must satisfy 2**TIDW >= NTHR.
// -----------------------------------------------------------------------------
module sparc_tlu_zcmp_pipe
  import sparc_tlu_zcmp_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned NTHR  = 4,
  parameter int unsigned TIDW  = 2,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_ref,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_mode,
  input  logic [TIDW-1:0]  in_tid,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_zero,
  output logic [TIDW-1:0]  out_tid,
  output logic [NTHR-1:0]  sticky_hit,
  input  logic [NTHR-1:0]  sticky_clr,
  output logic [CNTW-1:0]  match_cnt,
  input  logic             cnt_clr,
  output logic             busy
);

  localparam int unsigned NCHK = nchk(WIDTH, CHUNK);
  localparam int unsigned PADW = NCHK * CHUNK;

  // Zero-extension pads the last chunk with zero data and zero mask, so the
  // padding bits always read as "zero".
  logic [PADW-1:0] w_data_pad;
  logic [PADW-1:0] w_ref_pad;
  logic [PADW-1:0] w_mask_pad;
  logic [NCHK-1:0] w_chunk_zero;

  assign w_data_pad = PADW'(in_data);
  assign w_ref_pad  = PADW'(in_ref);
  assign w_mask_pad = PADW'(in_mask);

  for (genvar g = 0; g < NCHK; g++) begin : g_chunk
    sparc_tlu_zcmp_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .i_data    (w_data_pad[g*CHUNK +: CHUNK]),
      .i_ref_val (w_ref_pad[g*CHUNK +: CHUNK]),
      .i_mask    (w_mask_pad[g*CHUNK +: CHUNK]),
      .i_mode    (in_mode),
      .o_zero    (w_chunk_zero[g])
    );
  end

  // Pipeline registers
  logic            r_s1_vld;
  logic [NCHK-1:0] r_s1_flags;
  logic [TIDW-1:0] r_s1_tid;
  logic            r_s2_vld;
  logic            r_s2_zero;
  logic [TIDW-1:0] r_s2_tid;
  logic [NTHR-1:0] r_sticky;
  logic [CNTW-1:0] r_cnt;

  logic            w_s1_load;
  logic            w_s2_load;
  logic            w_deliver;
  logic            w_match;
  logic [NTHR-1:0] w_sticky_d;
  logic [CNTW-1:0] w_cnt_d;

  // in_rdy: stage 1 is free, or will be vacated into stage 2 this cycle.
  assign in_rdy    = ~r_s1_vld | ~r_s2_vld | out_rdy;
  assign w_s1_load = in_vld & in_rdy;
  assign w_s2_load = r_s1_vld & (~r_s2_vld | out_rdy);
  assign w_deliver = r_s2_vld & out_rdy;
  assign w_match   = w_deliver & r_s2_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_flags <= '0;
      r_s1_tid   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_vld   <= 1'b1;
        r_s1_flags <= w_chunk_zero;
        r_s1_tid   <= in_tid;
      end else if (w_s2_load) begin
        r_s1_vld   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_tid  <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_vld  <= 1'b1;
        r_s2_zero <= &r_s1_flags;
        r_s2_tid  <= r_s1_tid;
      end else if (w_deliver) begin
        r_s2_vld  <= 1'b0;
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins. Tags >= NTHR
  // match no index and so never set a flag.
  always_comb begin
    w_sticky_d = r_sticky & ~sticky_clr;
    for (int unsigned i = 0; i < NTHR; i++) begin
      if (w_match && (r_s2_tid == TIDW'(i))) begin
        w_sticky_d[i] = 1'b1;
      end
    end
  end

  // Counter: clear together with a match leaves a count of one.
  always_comb begin
    w_cnt_d = r_cnt;
    if (cnt_clr) begin
      w_cnt_d = w_match ? CNTW'(1) : '0;
    end else if (w_match && (r_cnt != {CNTW{1'b1}})) begin
      w_cnt_d = r_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
      r_cnt    <= '0;
    end else begin
      r_sticky <= w_sticky_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign out_vld    = r_s2_vld;
  assign out_zero   = r_s2_zero;
  assign out_tid    = r_s2_tid;
  assign sticky_hit = r_sticky;
  assign match_cnt  = r_cnt;
  assign busy       = r_s1_vld | r_s2_vld;

endmodule
